// File: rtl/mem_access_if.sv
// mem_access_if: bundles the upstream execute/memory register, the data-memory
// port and the downstream writeback register used by mem_access.
//   slave  : mem_access side (consumes mem_*, drives dmem_* requests, stall, wb_*)
//   master : environment side (drives mem_*, answers dmem_*, observes wb_*)
interface mem_access_if;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    // upstream execute/memory register
    logic              in_valid;
    logic [BYTE_W-1:0] mem_icode;
    logic [BYTE_W-1:0] mem_stat;
    logic [WORD_W-1:0] mem_vale;
    logic [WORD_W-1:0] mem_vala;
    logic [BYTE_W-1:0] mem_dste;
    logic [BYTE_W-1:0] mem_dstm;
    logic              stall;

    // data-memory port
    logic              dmem_req;
    logic              dmem_we;
    logic [WORD_W-1:0] dmem_addr;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_ack;
    logic              dmem_err;

    // downstream writeback register
    logic              wb_valid;
    logic [WORD_W-1:0] wb_vale;
    logic [WORD_W-1:0] wb_valm;
    logic [BYTE_W-1:0] wb_dste;
    logic [BYTE_W-1:0] wb_dstm;
    logic [BYTE_W-1:0] wb_stat;

    modport slave (
        input  in_valid, mem_icode, mem_stat, mem_vale, mem_vala, mem_dste, mem_dstm,
        input  dmem_rdata, dmem_ack, dmem_err,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output wb_valid, wb_vale, wb_valm, wb_dste, wb_dstm, wb_stat
    );

    modport master (
        output in_valid, mem_icode, mem_stat, mem_vale, mem_vala, mem_dste, mem_dstm,
        output dmem_rdata, dmem_ack, dmem_err,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  wb_valid, wb_vale, wb_valm, wb_dste, wb_dstm, wb_stat
    );
endinterface

// File: rtl/mem_access.sv
// mem_access: memory stage of a pipelined Y86 core. Non-memory instructions
// (or ones already carrying a fault status) pass straight to the writeback
// register in one cycle; loads/stores issue a data-memory request and stall
// upstream until dmem_ack or until TIMEOUT cycles expire (forced ADR fault).
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_access_if.slave (upstream inputs, stall, dmem port, wb_* outputs)
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_access_if.slave  bus
);
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT) + 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    localparam logic [BYTE_W-1:0] STAT_AOK = 8'h01;
    localparam logic [BYTE_W-1:0] STAT_ADR = 8'h03;
    localparam logic [BYTE_W-1:0] REG_NONE = 8'h0F;

    logic [0:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wb_valid_q, wb_valid_d;
    logic [WORD_W-1:0] wb_vale_q, wb_vale_d;
    logic [WORD_W-1:0] wb_valm_q, wb_valm_d;
    logic [BYTE_W-1:0] wb_dste_q, wb_dste_d;
    logic [BYTE_W-1:0] wb_dstm_q, wb_dstm_d;
    logic [BYTE_W-1:0] wb_stat_q, wb_stat_d;

    logic is_read, is_write, addr_from_a;
    logic accept, timeout, done, fault, in_access;

    // Opcode decode: popl/ret address the stack through valA.
    always_comb begin
        is_read     = 1'b0;
        is_write    = 1'b0;
        addr_from_a = 1'b0;
        case (bus.mem_icode)
            8'h5:    is_read = 1'b1;
            8'h9,
            8'hB:    begin is_read = 1'b1; addr_from_a = 1'b1; end
            8'h4,
            8'hA,
            8'h8:    is_write = 1'b1;
            default: ;
        endcase
    end

    assign in_access = (state_q == ACCESS);
    assign accept    = (state_q == IDLE) && bus.in_valid && (is_read || is_write)
                       && (bus.mem_stat == STAT_AOK);
    assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done      = in_access && (bus.dmem_ack || timeout);
    // A real ack beats a simultaneous timeout; only then is err meaningful.
    assign fault     = bus.dmem_ack ? bus.dmem_err : 1'b1;

    // Memory port and stall; rst gating keeps stall low while reset is asserted.
    always_comb begin
        bus.dmem_req   = in_access;
        bus.dmem_we    = in_access && is_write;
        bus.dmem_addr  = in_access ? (addr_from_a ? bus.mem_vala : bus.mem_vale) : '0;
        bus.dmem_wdata = in_access ? bus.mem_vala : '0;
        bus.stall      = !rst && (accept || (in_access && !done));
    end

    // Next-state and writeback register contents.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = wb_valid_q;
        wb_vale_d  = wb_vale_q;
        wb_valm_d  = wb_valm_q;
        wb_dste_d  = wb_dste_q;
        wb_dstm_d  = wb_dstm_q;
        wb_stat_d  = wb_stat_q;
        case (state_q)
            IDLE: begin
                if (!bus.in_valid) begin
                    wb_valid_d = 1'b0;
                end else if (accept) begin
                    state_d    = ACCESS;
                    cnt_d      = '0;
                    wb_valid_d = 1'b0;
                end else begin
                    wb_valid_d = 1'b1;
                    wb_vale_d  = bus.mem_vale;
                    wb_valm_d  = '0;
                    wb_dste_d  = bus.mem_dste;
                    wb_dstm_d  = bus.mem_dstm;
                    wb_stat_d  = bus.mem_stat;
                end
            end
            ACCESS: begin
                if (done) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    wb_valid_d = 1'b1;
                    wb_vale_d  = bus.mem_vale;
                    if (fault) begin
                        wb_valm_d = '0;
                        wb_dste_d = REG_NONE;
                        wb_dstm_d = REG_NONE;
                        wb_stat_d = STAT_ADR;
                    end else begin
                        wb_valm_d = is_read ? bus.dmem_rdata : '0;
                        wb_dste_d = bus.mem_dste;
                        wb_dstm_d = bus.mem_dstm;
                        wb_stat_d = bus.mem_stat;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and writeback registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_vale_q  <= '0;
            wb_valm_q  <= '0;
            wb_dste_q  <= REG_NONE;
            wb_dstm_q  <= REG_NONE;
            wb_stat_q  <= STAT_AOK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_vale_q  <= wb_vale_d;
            wb_valm_q  <= wb_valm_d;
            wb_dste_q  <= wb_dste_d;
            wb_dstm_q  <= wb_dstm_d;
            wb_stat_q  <= wb_stat_d;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_vale  = wb_vale_q;
    assign bus.wb_valm  = wb_valm_q;
    assign bus.wb_dste  = wb_dste_q;
    assign bus.wb_dstm  = wb_dstm_q;
    assign bus.wb_stat  = wb_stat_q;
endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: scoreboard bench for mem_access. The driver acts as both the
// upstream stage and the data memory, choosing each access's ack latency up
// front; the expected writeback is derived from the instruction rules and
// queued, and an independent monitor pops it whenever wb_valid is seen.
module tb_mem_access;
    localparam int unsigned TO = 16;

    typedef struct {
        logic [31:0] vale;
        logic [31:0] valm;
        logic [7:0]  dste;
        logic [7:0]  dstm;
        logic [7:0]  stat;
    } wb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;
    logic exp_wbv = 1'b0;
    wb_t  sb[$];

    mem_access_if bus();
    mem_access #(.TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with wb_valid carries exactly one result.
    always @(negedge clk) begin
        if (!rst && bus.wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wb_unexpected: got wb_valid=1 want no pending result");
            end else begin
                wb_t e;
                e = sb.pop_front();
                chk("wb_vale", bus.wb_vale, e.vale);
                chk("wb_valm", bus.wb_valm, e.valm);
                chk("wb_dste", 32'(bus.wb_dste), 32'(e.dste));
                chk("wb_dstm", 32'(bus.wb_dstm), 32'(e.dstm));
                chk("wb_stat", 32'(bus.wb_stat), 32'(e.stat));
            end
        end
    end

    // Reference rules: what the writeback register must hold for one instruction.
    function automatic wb_t model(input logic [7:0] icode, input logic [7:0] stat,
                                  input logic [31:0] vale, input logic [7:0] dste,
                                  input logic [7:0] dstm, input int lat,
                                  input logic err, input logic [31:0] rdata);
        wb_t r;
        logic rd, wr;
        rd = (icode == 8'h5) || (icode == 8'h9) || (icode == 8'hB);
        wr = (icode == 8'h4) || (icode == 8'hA) || (icode == 8'h8);
        r.vale = vale;
        r.valm = 32'h0;
        r.dste = dste;
        r.dstm = dstm;
        r.stat = stat;
        if ((rd || wr) && stat == 8'h01) begin
            if (lat >= int'(TO) || err) begin
                r.dste = 8'hF;
                r.dstm = 8'hF;
                r.stat = 8'h03;
            end else if (rd) begin
                r.valm = rdata;
            end
        end
        return r;
    endfunction

    task automatic idle_cycle();
        bus.in_valid   = 1'b0;
        bus.mem_icode  = 8'($urandom_range(0, 11));
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_err   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;
        @(negedge clk);
        chk("idle_wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
        chk("idle_req", 32'(bus.dmem_req), 32'h0);
        chk("idle_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        exp_wbv = 1'b0;
        bus.dmem_ack = 1'b0;
    endtask

    task automatic do_txn(input logic [7:0] icode, input logic [7:0] stat,
                          input logic [31:0] vale, input logic [31:0] vala,
                          input logic [7:0] dste, input logic [7:0] dstm,
                          input int lat, input logic err, input logic [31:0] rdata);
        logic rd, wr, go, last;
        rd = (icode == 8'h5) || (icode == 8'h9) || (icode == 8'hB);
        wr = (icode == 8'h4) || (icode == 8'hA) || (icode == 8'h8);
        go = (rd || wr) && stat == 8'h01;
        bus.in_valid  = 1'b1;
        bus.mem_icode = icode;
        bus.mem_stat  = stat;
        bus.mem_vale  = vale;
        bus.mem_vala  = vala;
        bus.mem_dste  = dste;
        bus.mem_dstm  = dstm;
        bus.dmem_ack  = 1'b0;
        sb.push_back(model(icode, stat, vale, dste, dstm, lat, err, rdata));
        @(negedge clk);
        chk("issue_wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
        chk("issue_stall", 32'(bus.stall), 32'(go));
        chk("issue_req", 32'(bus.dmem_req), 32'h0);
        @(posedge clk);
        #1;
        exp_wbv = 1'b1;
        if (go) begin
            exp_wbv = 1'b0;
            for (int k = 0; k < 40; k++) begin
                last = (k == lat) || (k == int'(TO) - 1);
                bus.dmem_ack   = (k == lat);
                bus.dmem_err   = (k == lat) ? err : 1'($urandom_range(0, 1));
                bus.dmem_rdata = (k == lat) ? rdata : $urandom;
                @(negedge clk);
                chk("acc_wb_valid", 32'(bus.wb_valid), 32'h0);
                chk("acc_req", 32'(bus.dmem_req), 32'h1);
                chk("acc_we", 32'(bus.dmem_we), 32'(wr));
                chk("acc_addr", bus.dmem_addr, (icode == 8'h9 || icode == 8'hB) ? vala : vale);
                chk("acc_wdata", bus.dmem_wdata, vala);
                chk("acc_stall", 32'(bus.stall), 32'(!last));
                @(posedge clk);
                #1;
                bus.dmem_ack = 1'b0;
                if (last) break;
                if (k == 39) begin
                    total++;
                    bad++;
                    $display("FAIL acc_bound: got no completion want completion within 40 cycles");
                end
            end
            exp_wbv = 1'b1;
        end
    endtask

    // Reset during ACCESS: request and stall drop at once, no result emerges,
    // and a stale ack afterwards is ignored.
    task automatic reset_mid_access();
        bus.in_valid  = 1'b1;
        bus.mem_icode = 8'h5;
        bus.mem_stat  = 8'h01;
        bus.mem_vale  = 32'h300;
        bus.mem_vala  = 32'h0;
        bus.mem_dste  = 8'h3;
        bus.mem_dstm  = 8'h4;
        bus.dmem_ack  = 1'b0;
        @(negedge clk);
        chk("rst_issue_wb_valid", 32'(bus.wb_valid), 32'(exp_wbv));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pre_req", 32'(bus.dmem_req), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_req", 32'(bus.dmem_req), 32'h0);
        chk("rst_we", 32'(bus.dmem_we), 32'h0);
        chk("rst_addr", bus.dmem_addr, 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'h0);
        chk("rst_wb_vale", bus.wb_vale, 32'h0);
        chk("rst_wb_valm", bus.wb_valm, 32'h0);
        chk("rst_wb_dste", 32'(bus.wb_dste), 32'hF);
        chk("rst_wb_dstm", 32'(bus.wb_dstm), 32'hF);
        chk("rst_wb_stat", 32'(bus.wb_stat), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        bus.dmem_ack = 1'b1;
        bus.dmem_err = 1'b0;
        exp_wbv = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(bus.dmem_req), 32'h0);
        chk("late_ack_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_wb_valid", 32'(bus.wb_valid), 32'h0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.mem_icode  = 8'h0;
        bus.mem_stat   = 8'h1;
        bus.mem_vale   = 32'h0;
        bus.mem_vala   = 32'h0;
        bus.mem_dste   = 8'hF;
        bus.mem_dstm   = 8'hF;
        bus.dmem_rdata = 32'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_err   = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_wb_valid", 32'(bus.wb_valid), 32'h0);
        chk("reset_wb_dste", 32'(bus.wb_dste), 32'hF);
        chk("reset_wb_dstm", 32'(bus.wb_dstm), 32'hF);
        chk("reset_wb_stat", 32'(bus.wb_stat), 32'h1);
        chk("reset_req", 32'(bus.dmem_req), 32'h0);
        chk("reset_stall", 32'(bus.stall), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // directed scenarios
        do_txn(8'h6, 8'h1, 32'h12, 32'h7, 8'h0, 8'hF, 0, 1'b0, 32'h0);
        do_txn(8'h5, 8'h1, 32'h100, 32'h0, 8'hF, 8'h2, 3, 1'b0, 32'hDEADBEEF);
        do_txn(8'hB, 8'h1, 32'h204, 32'h200, 8'h4, 8'h6, 0, 1'b0, 32'h55AA1234);
        do_txn(8'h4, 8'h1, 32'h40, 32'hCAFE, 8'hF, 8'hF, 1, 1'b1, 32'h0);
        do_txn(8'h8, 8'h1, 32'h80, 32'h11, 8'h4, 8'hF, 100, 1'b0, 32'h0);
        do_txn(8'h9, 8'h1, 32'h84, 32'h80, 8'h4, 8'hF, 15, 1'b0, 32'h1234);
        do_txn(8'h5, 8'h3, 32'h10, 32'h0, 8'h1, 8'h2, 0, 1'b0, 32'h0);
        idle_cycle();
        reset_mid_access();

        // randomized traffic
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_cycle();
            end else begin
                logic [7:0] st;
                int lat;
                st  = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 4)) : 8'h1;
                lat = ($urandom_range(0, 4) == 0) ? int'($urandom_range(13, 18))
                                                  : int'($urandom_range(0, 5));
                do_txn(8'($urandom_range(0, 11)), st, $urandom, $urandom,
                       8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
                       lat, ($urandom_range(0, 3) == 0), $urandom);
            end
        end

        repeat (3) idle_cycle();
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles in ACCESS waiting for dmem_ack before forced address error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  execute/memory register holds a valid instruction.
REQ-005 mem_icode  input  `BYTE  instruction code.
REQ-006 mem_stat  input  `BYTE  upstream status (AOK=1, HLT=2, ADR=3, INS=4).
REQ-007 mem_valE  input  `WORD  ALU result.
REQ-008 mem_valA  input  `WORD  operand A; holds valP for call.
REQ-009 mem_dstE, mem_dstM  input  `BYTE each  destination register IDs; 0xF = none.
REQ-010 dmem_req, dmem_we  output  1 each  data-memory request strobe and write enable.
REQ-011 dmem_addr, dmem_wdata  output  `WORD each  data-memory address and write data.
REQ-012 dmem_rdata  input  `WORD  read data, valid on the dmem_ack cycle.
REQ-013 dmem_ack, dmem_err  input  1 each  access complete; access faulted (sampled only with ack).
REQ-014 stall  output  1  upstream must hold all mem_* inputs stable while high.
REQ-015 wb_valid  output  1  registered outputs hold a valid result for the downstream writeback register.
REQ-016 wb_valE, wb_valM  output  `WORD each  registered ALU result and memory read data.
REQ-017 wb_dstE, wb_dstM  output  `BYTE each  registered destinations.
REQ-018 wb_stat  output  `BYTE  registered resulting status.

Function
REQ-019 Memory ops: reads are mrmovl 0x5, popl 0xB, ret 0x9; writes are rmmovl 0x4, pushl 0xA, call 0x8; all other icodes are non-memory.
REQ-020 Address: mem_valA for popl/ret; mem_valE for all other memory ops. Write data is always mem_valA.
REQ-021 FSM states are IDLE and ACCESS; reset state is IDLE.
REQ-022 IDLE, in_valid=0: wb_valid<=0 on next edge; other wb_* hold.
REQ-023 IDLE, in_valid=1, non-memory op or mem_stat!=AOK: no request; next edge wb_valid<=1, wb_valE<=mem_valE, wb_valM<=0, dsts and stat passed through; 1-cycle latency; stall=0.
REQ-024 IDLE, in_valid=1, memory op, mem_stat=AOK: stall=1 combinationally in that cycle; next edge state<=ACCESS, counter<=0, wb_valid<=0.
REQ-025 ACCESS: dmem_req=1; dmem_we=1 only for write ops; addr/wdata per REQ-020; stall=1 except in the dmem_ack cycle.
REQ-026 ACCESS with dmem_ack=1: stall=0; next edge state<=IDLE, wb_valid<=1, wb_valE<=mem_valE, wb_valM<=dmem_rdata for reads and 0 for writes, dsts and stat passed through.
REQ-027 dmem_ack=1 with dmem_err=1: next edge wb_stat<=ADR (3), wb_dstE<=0xF, wb_dstM<=0xF, wb_valM<=0; otherwise as REQ-026.
REQ-028 ACCESS without ack: counter increments each cycle; when counter reaches TIMEOUT-1 with no ack, treat the cycle as ack with err (REQ-027); counter width is ceil(log2(TIMEOUT))+1.
REQ-029 dmem_req, dmem_we are 0 outside ACCESS; dmem_addr, dmem_wdata are 0 when dmem_req=0.
REQ-030 Back-to-back: in the ack cycle, a newly presented instruction is not accepted; it is accepted in IDLE on the following cycle.
REQ-031 Ack and timeout in the same cycle: ack wins; err follows dmem_err.

Reset
REQ-032 rst=1 forces immediately state=IDLE, counter=0, dmem_req=0, dmem_we=0, stall=0, wb_valid=0, wb_valE=0, wb_valM=0, wb_dstE=0xF, wb_dstM=0xF, wb_stat=AOK (1).
REQ-033 rst asserted during ACCESS abandons the access with no wb_valid pulse; a late dmem_ack after reset release is ignored in IDLE.

Verification
REQ-034 Non-memory op (icode 0x6, valE=0x12, dstE=0x0): no dmem_req, stall=0; next cycle wb_valid=1, wb_valE=0x12, wb_dstE=0x0.
REQ-035 mrmovl, valE=0x100, ack after 3 cycles with rdata=0xDEADBEEF: dmem_addr=0x100, we=0, stall high 3 cycles; then wb_valM=0xDEADBEEF, wb_stat=1.
REQ-036 popl, valA=0x200, valE=0x204, immediate ack: dmem_addr=0x200, wb_valE=0x204, wb_dstE and wb_dstM passed through.
REQ-037 rmmovl with ack+err: dmem_we=1; result wb_stat=3, wb_dstE=wb_dstM=0xF.
REQ-038 call with no ack, TIMEOUT=16: req held 16 cycles, then wb_stat=3, state IDLE, stall released.
REQ-039 rst pulse mid-ACCESS: dmem_req and stall drop asynchronously, all wb_* at reset values, no wb_valid pulse.
